// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, CTRL bit positions and control struct for timer_bank
package timer_pkg;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // Packed so that a cast to W bits gives the CTRL read layout; bit 3 is never stored.
  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [2:0] bits);
    ctrl_t c;
    c.en       = bits[CTRL_EN];
    c.periodic = bits[CTRL_PERIODIC];
    c.irq_en   = bits[CTRL_IRQ_EN];
    return c;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - peripheral bus bundle between the z80 side and timer_bank
interface timer_bank_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int AW = $clog2(N) + 2;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          irq;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, irq);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter channel: RELOAD, CTRL, COUNT and terminal-count flag
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         wr_reload,
  input  logic         wr_ctrl,
  input  logic         wr_status,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] reload,
  output logic [W-1:0] count,
  output ctrl_t        ctrl,
  output logic         tc
);
  logic  load;
  ctrl_t wctrl;

  assign wctrl = decode_ctrl(wdata[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
      count  <= '0;
      ctrl   <= '0;
      tc     <= 1'b0;
      load   <= 1'b0;
    end else begin
      if (wr_reload) reload <= wdata;
      // Clear first so a tc raised below in the same cycle wins.
      if (wr_status && wdata[0]) tc <= 1'b0;
      if (load) begin
        count <= reload;
        load  <= 1'b0;
      end else if (ctrl.en && tick) begin
        if (count != '0) begin
          count <= count - W'(1);
        end else begin
          tc <= 1'b1;
          if (ctrl.periodic) count <= reload;
          else               ctrl.en <= 1'b0;
        end
      end
      if (wr_ctrl) begin
        ctrl <= wctrl;
        load <= wctrl.en && !ctrl.en;
      end
    end
  end
endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - N timer channels behind a shared prescaler, register read mux and irq
module timer_bank
  import timer_pkg::*;
#(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  timer_bank_if.slave bus
);
  localparam int AW = $clog2(N) + 2;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic [AW-1:0] chan;
  logic [1:0]    reg_sel;
  logic [W-1:0]  rd_val;

  logic [W-1:0]  reload_q [N];
  logic [W-1:0]  count_q  [N];
  ctrl_t         ctrl_q   [N];
  logic [N-1:0]  tc_q;
  logic [N-1:0]  irq_vec;

  assign tick    = (pre == PW'(DIV - 1));
  assign chan    = bus.addr >> 2;
  assign reg_sel = bus.addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic hit;
    assign hit = (chan == AW'(i));

    timer_channel #(.W(W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .wr_reload (bus.wr_en && hit && (reg_sel == REG_RELOAD)),
      .wr_ctrl   (bus.wr_en && hit && (reg_sel == REG_CTRL)),
      .wr_status (bus.wr_en && hit && (reg_sel == REG_STATUS)),
      .wdata     (bus.wdata),
      .reload    (reload_q[i]),
      .count     (count_q[i]),
      .ctrl      (ctrl_q[i]),
      .tc        (tc_q[i])
    );

    assign irq_vec[i] = tc_q[i] & ctrl_q[i].irq_en;
  end

  // Mux reads current register state, so a same-cycle write or tick is not yet visible.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N; i++) begin
      if (chan == AW'(i)) begin
        case (reg_sel)
          REG_RELOAD: rd_val = reload_q[i];
          REG_CTRL:   rd_val = W'(ctrl_q[i]);
          REG_COUNT:  rd_val = count_q[i];
          default:    rd_val = W'(tc_q[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
      bus.irq   <= 1'b0;
    end else begin
      if (bus.rd_en) bus.rdata <= rd_val;
      bus.irq <= |irq_vec;
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed bench for timer_bank (DIV=4 main instance, DIV=1 second instance)
module tb_timer_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pcnt;
  int   vectors;
  int   miscompares;

  always #5 clk = ~clk;

  // Posedges since reset release; with DIV=4 the prescaler ticks on multiples of 4.
  always @(posedge clk) pcnt <= rst ? 0 : pcnt + 1;

  timer_bank_if #(.W(8), .N(4)) bus  ();
  timer_bank_if #(.W(8), .N(4)) bus1 ();

  timer_bank #(.W(8), .N(4), .DIV(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  timer_bank #(.W(8), .N(4), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_p(input int n);
    if (pcnt > n) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_p: observed edge %0d expected at most %0d", pcnt, n);
    end
    while (pcnt < n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rdchk(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.rd_en = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check(tag, 32'(bus.rdata), 32'(exp));
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    bus1.wr_en = 1'b1; bus1.addr = a; bus1.wdata = d;
    @(negedge clk);
    bus1.wr_en = 1'b0;
  endtask

  task automatic rdchk1(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus1.rd_en = 1'b1; bus1.addr = a;
    @(negedge clk);
    bus1.rd_en = 1'b0;
    check(tag, 32'(bus1.rdata), 32'(exp));
  endtask

  initial begin
    bus.wr_en  = 1'b0; bus.rd_en  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.addr = '0; bus1.wdata = '0;

    @(negedge clk);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    check("rst_rdata1", 32'(bus1.rdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rdchk(4'd1, 8'h00, "rst_ctrl");
    rdchk(4'd0, 8'h00, "rst_reload");
    rdchk(4'd2, 8'h00, "rst_count");
    rdchk(4'd15, 8'h00, "rst_status3");

    // ch0 periodic, RELOAD=3: load at edge 11, ticks 12/16/20 count down, tc at 24.
    wait_p(8);
    wr(4'd0, 8'd3);
    wr(4'd1, 8'b0111);
    wait_p(23);
    check("irq_pre_tc", 32'(bus.irq), 32'h0);
    rdchk(4'd3, 8'h00, "status_pre_tc");
    check("irq_lag", 32'(bus.irq), 32'h0);
    rdchk(4'd3, 8'h01, "tc_set");
    check("irq_set", 32'(bus.irq), 32'h1);
    rdchk(4'd2, 8'h03, "reloaded");
    wr(4'd3, 8'h01);
    wait_p(28);
    check("irq_clr", 32'(bus.irq), 32'h0);

    // ch1 one-shot RELOAD=2: load at 31, tc at 40, same edge as ch0's second tc.
    wr(4'd4, 8'd2);
    wr(4'd5, 8'b0101);
    wait_p(39);
    wr(4'd3, 8'h01);
    rdchk(4'd3, 8'h01, "collision_set_wins");
    rdchk(4'd5, 8'h04, "oneshot_ctrl");
    rdchk(4'd6, 8'h00, "oneshot_count");
    rdchk(4'd7, 8'h01, "oneshot_tc");

    // Disable ch0 at edge 45 with COUNT=2; count and tc must freeze.
    wr(4'd1, 8'h00);
    wait_p(60);
    rdchk(4'd2, 8'h02, "frozen_count");
    rdchk(4'd3, 8'h01, "tc_kept");
    rdchk(4'd6, 8'h00, "oneshot_holds");
    check("irq_ch1", 32'(bus.irq), 32'h1);
    wr(4'd7, 8'h01);
    wait_p(65);
    check("irq_masked_ch0", 32'(bus.irq), 32'h0);
    wr(4'd3, 8'h01);

    // ch2 RELOAD=1 no irq_en (load 69), ch3 RELOAD=5 irq_en (load 71).
    wr(4'd8, 8'd1);
    wr(4'd9, 8'b0011);
    wr(4'd12, 8'd5);
    wr(4'd13, 8'b0111);
    wait_p(75);
    rdchk(4'd14, 8'h04, "pre_update");
    @(negedge clk);
    check("rdata_hold", 32'(bus.rdata), 32'h4);
    wait_p(78);
    check("irq_masked_ch2", 32'(bus.irq), 32'h0);
    rdchk(4'd11, 8'h01, "ch2_tc");
    wr(4'd9, 8'b0111);
    wait_p(81);
    check("irq_unmasked", 32'(bus.irq), 32'h1);
    rdchk(4'd10, 8'h00, "no_reload_when_running");
    wait_p(93);
    rdchk(4'd15, 8'h01, "ch3_tc");

    // DIV=1 instance: periodic RELOAD=0, load at 96, tc from 97 on every edge.
    wr1(4'd1, 8'b0011);
    rdchk1(4'd3, 8'h00, "d1_status_idle");
    rdchk1(4'd3, 8'h00, "d1_load_cycle");
    wr1(4'd3, 8'h01);
    rdchk1(4'd3, 8'h01, "d1_tc_every_tick");
    wr1(4'd0, 8'hFF);
    rdchk1(4'd2, 8'h00, "d1_old_reload");
    rdchk1(4'd2, 8'hFF, "d1_new_reload");
    rdchk1(4'd2, 8'hFE, "d1_decrement");

    // ch0 one-shot RELOAD=5 loaded at 106, then reset before the tick at 108.
    wr(4'd0, 8'd5);
    wr(4'd1, 8'b0001);
    @(negedge clk);
    rdchk(4'd2, 8'h05, "count_before_rst");
    check("irq_before_rst", 32'(bus.irq), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_rdata", 32'(bus.rdata), 32'h0);
    check("rst_async_irq", 32'(bus.irq), 32'h0);
    check("rst_async_rdata1", 32'(bus1.rdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rdchk(4'd2, 8'h00, "rst_count0");
    rdchk(4'd1, 8'h00, "rst_ctrl0");
    rdchk(4'd15, 8'h00, "rst_status3_mid");
    repeat (12) @(negedge clk);
    rdchk(4'd3, 8'h00, "no_tc_after_rst");
    check("irq_after_rst", 32'(bus.irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
